// File: rtl/lfsr_pkg.sv
// Shared types and tap tables for the LFSR sequencer and its step function.
package lfsr_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LOCK,
        HALT
    } lfsr_state_t;

    localparam int MAX_N = 16;

    // Fibonacci tap masks for maximal-length sequences; bit i selects tap i+1
    function automatic logic [MAX_N-1:0] taps(input int n);
        case (n)
            2:       taps = 16'h0003;
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = '0;
        endcase
    endfunction

    // Reverses the low n bits of v; the Galois polynomial is the mirrored tap mask
    function automatic logic [MAX_N-1:0] bitrev(input logic [MAX_N-1:0] v, input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int j = 0; j < MAX_N; j++) begin
            if (j < n) begin
                r[j] = v[n-1-j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational next-state function of the LFSR, Fibonacci or Galois form.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int N      = 8,
    parameter bit GALOIS = 1'b0
) (
    input  logic [N-1:0] state,
    output logic [N-1:0] nxt
);

    localparam logic [MAX_N-1:0] TAPS_FULL  = taps(N);
    localparam logic [MAX_N-1:0] GPOLY_FULL = bitrev(TAPS_FULL, N);
    localparam logic [N-1:0]     TAP_MASK   = TAPS_FULL[N-1:0];
    localparam logic [N-1:0]     GPOLY      = GPOLY_FULL[N-1:0];

    // Fibonacci shifts in the parity of the tapped bits; Galois folds the
    // outgoing MSB back into the register through the mirrored polynomial
    always_comb begin
        if (GALOIS) begin
            nxt = {state[N-2:0], 1'b0} ^ (state[N-1] ? GPOLY : '0);
        end else begin
            nxt = {state[N-2:0], ^(state & TAP_MASK)};
        end
    end

endmodule

// File: rtl/lfsr_seq.sv
// LFSR sequencer: seeded stepping, period measurement and zero-seed lock-up detection.
module lfsr_seq
    import lfsr_pkg::*;
#(
    parameter int N      = 8,
    parameter bit GALOIS = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_seed,
    input  logic [N-1:0] seed_data,
    input  logic         enable,
    input  logic         one_shot,
    output logic [N-1:0] lfsr_data,
    output logic         lfsr_done,
    output logic         busy,
    output logic         lockup,
    output logic [N-1:0] period,
    output logic         period_valid
);

    generate
        if (N < 2 || N > MAX_N) begin : g_bad_width
            $error("lfsr_seq: N must be in the range 2..16");
        end
    endgenerate

    localparam logic [N-1:0] CNT_MAX = '1;

    lfsr_state_t  state;
    logic [N-1:0] shift_reg;
    logic [N-1:0] seed_q;
    logic [N-1:0] step_cnt;
    logic [N-1:0] nxt;
    logic         os_q;

    lfsr_step #(
        .N      (N),
        .GALOIS (GALOIS)
    ) u_step (
        .state (shift_reg),
        .nxt   (nxt)
    );

    assign lfsr_data = shift_reg;

    // Control FSM: a load always wins, RUN steps while enabled and closes a
    // period when the register comes back to the seed; busy/lockup are
    // registered alongside the state so every output comes from a flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            seed_q       <= '0;
            step_cnt     <= '0;
            period       <= '0;
            os_q         <= 1'b0;
            lfsr_done    <= 1'b0;
            busy         <= 1'b0;
            lockup       <= 1'b0;
            period_valid <= 1'b0;
        end else begin
            lfsr_done <= 1'b0;
            if (load_seed) begin
                shift_reg    <= seed_data;
                seed_q       <= seed_data;
                os_q         <= one_shot;
                step_cnt     <= '0;
                period_valid <= 1'b0;
                if (seed_data == '0) begin
                    state  <= LOCK;
                    busy   <= 1'b0;
                    lockup <= 1'b1;
                end else begin
                    state  <= RUN;
                    busy   <= 1'b1;
                    lockup <= 1'b0;
                end
            end else if (state == RUN && enable) begin
                shift_reg <= nxt;
                if (nxt == seed_q) begin
                    lfsr_done    <= 1'b1;
                    period       <= (step_cnt == CNT_MAX) ? CNT_MAX : step_cnt + 1'b1;
                    period_valid <= 1'b1;
                    step_cnt     <= '0;
                    if (os_q) begin
                        state <= HALT;
                        busy  <= 1'b0;
                    end
                end else if (step_cnt != CNT_MAX) begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/lfsr_seq.md
Name: lfsr_seq

Overview:
- Parametrised maximal-length LFSR sequencer.
- Width is configurable from 2 to 16 bits, in Fibonacci or Galois form.
- Has enable-gated stepping and a one-shot or free-running period mode.
- Measures period on return to seed, and detects lock-up on an all-zero seed.
- Used as a pattern/PRBS source and sequence-period checker in the team's datapath test harnesses.

Parameters:
- N, 8, register width; legal 2..16, any other value is an elaboration error.
- GALOIS, 0, 0 = Fibonacci (external XOR) form; 1 = Galois (internal XOR) form.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- load_seed  input  1  load seed_data; has priority over enable
- seed_data  input  N  seed value
- enable  input  1  advance one step per cycle while RUN
- one_shot  input  1  sampled at load_seed; 1 = stop after one full period
- lfsr_data  output  N  current register state
- lfsr_done  output  1  one-cycle pulse when state returns to seed
- busy  output  1  high while in RUN
- lockup  output  1  high while in LOCK (the loaded seed was zero)
- period  output  N  steps of the last completed period
- period_valid  output  1  period holds a measured value

Behaviour:
- Async reset (reset==0):
  - shift_reg, seed_q, step_cnt, period = 0.
  - FSM = IDLE.
  - lfsr_done, busy, lockup, period_valid = 0.
- All outputs are registered, with no combinational path from inputs.
- FSM states: IDLE, RUN, LOCK, HALT.
  - IDLE: register holds; wait for load_seed.
  - load_seed in any state:
    - shift_reg <= seed_data, seed_q <= seed_data, os_q <= one_shot, step_cnt <= 0, period_valid <= 0.
    - Next state is LOCK if seed_data == 0, else RUN.
    - lfsr_done is not asserted on this edge.
  - RUN with enable=1 and no load:
    - shift_reg <= nxt, step_cnt <= step_cnt + 1.
    - If nxt == seed_q:
      - lfsr_done <= 1 for one cycle, period <= step_cnt + 1, period_valid <= 1, step_cnt <= 0.
      - Next state is HALT if os_q, else stay in RUN.
  - RUN with enable=0: everything holds; lfsr_done is 0.
  - LOCK: register holds at 0; lockup = 1; exit only via load_seed.
  - HALT: register holds at seed; busy = 0; period stays valid; exit only via load_seed.
- Next-state functions:
  - Fibonacci: nxt = {s[N-2:0], ^(s & TAPS(N))}.
  - Galois: nxt = {s[N-2:0],1'b0} ^ (s[N-1] ? GPOLY(N) : 0), where GPOLY(N)[j] = TAPS(N)[N-1-j] (bit reverse of TAPS).
  - Both forms give period 2^N-1 for any non-zero seed.
- TAPS(N) in hex (bit i = tap i+1):
  - 2:3, 3:6, 4:C, 5:14, 6:30, 7:60, 8:B8
  - 9:110, 10:240, 11:500, 12:829, 13:100D
  - 14:2015, 15:6000, 16:D008
- Width rules:
  - step_cnt and period are N bits; the maximum 2^N-1 fits without wrap.
  - step_cnt saturates at all-ones as a guard and never wraps to 0.
- Simultaneous events:
  - load_seed together with enable: load wins and no step occurs.
  - load_seed on the edge the return-to-seed step would occur: load wins and no done pulse.
- Reset asserted mid-period aborts immediately to the reset values; period_valid is cleared.
- Free-running mode: lfsr_done pulses every 2^N-1 enabled cycles; period is re-latched each time with the same value.

Decomposition:
- Package lfsr_pkg holds:
  - state enum lfsr_state_t {IDLE, RUN, LOCK, HALT};
  - constant MAX_N = 16;
  - function taps(int n) returning logic[MAX_N-1:0] from the table above;
  - function bitrev for deriving GPOLY.
- One natural sub-module, lfsr_step: a combinational next-state function, parametrised by N and GALOIS. It lets the bench compute a reference model from the same taps.

Test Plan:
- N=4, GALOIS=0, seed 0001, enable held high:
  - sequence 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001;
  - lfsr_done pulses on the 15th step; period=15, period_valid=1.
- N=4, GALOIS=1, seed 0001:
  - after 4 steps lfsr_data=0011, after 7 steps 1011;
  - returns to 0001 after 15 steps; period=15.
- N=8, GALOIS=0, seed A5, one_shot=1:
  - exactly one lfsr_done after 255 enabled cycles;
  - state HALT, busy=0, lfsr_data=A5 held while enable stays high.
- Seed 0:
  - lockup=1, busy=0, lfsr_data stays 0 for 20 cycles;
  - reload with seed 1 clears lockup and resumes stepping.
- N=4, seed 0001, enable toggled 1/0 each cycle: lfsr_done after 30 cycles (15 enabled steps); period=15.
- Reset pulse mid-run, then load_seed asserted with enable high:
  - after reset all outputs read 0;
  - after load, lfsr_data equals the seed with no step that cycle.
